// File: rtl/guineveer_uart_rx_monitor_if.sv
// Byte stream from the UART monitor FIFO to its consumer.
interface guineveer_uart_rx_monitor_if #(
   parameter int unsigned FIFO_DEPTH = 8
);
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    data_o;
   logic          valid_o;
   logic          ready_i;
   logic [LW-1:0] level_o;

   modport master (output data_o, output valid_o, output level_o, input ready_i);
   modport slave  (input data_o, input valid_o, input level_o, output ready_i);
endinterface

// File: rtl/guineveer_uart_rx_monitor.sv
// Bench-side 8N1 UART receiver with byte FIFO, framing/overflow flags.
// Optional GUINEVEER_UART_RX_EOT_EN adds a sticky eot_o set on a received 8'h04.
module guineveer_uart_rx_monitor #(
   parameter int unsigned CLKS_PER_BIT = 289,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rx_i,
   input  logic clr_i,
   output logic frame_err_o,
   output logic overflow_o,
   guineveer_uart_rx_monitor_if.master out
`ifdef GUINEVEER_UART_RX_EOT_EN
   ,
   output logic eot_o
`endif
);
   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [TW-1:0] HALF   = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   logic          rx_q1, rx_q2;
   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          tick_c, push_c;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_q1 <= 1'b1;
         rx_q2 <= 1'b1;
      end else begin
         rx_q1 <= rx_i;
         rx_q2 <= rx_q1;
      end
   end

   assign tick_c = (timer == '0);
   assign push_c = (state == S_STOP) && tick_c && rx_q2;

   // Receive FSM; all sampling at mid-bit on the synchronized line
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= S_IDLE;
         timer       <= '0;
         idx         <= '0;
         shreg       <= '0;
         frame_err_o <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rx_q2) begin
                  state <= S_START;
                  timer <= HALF;
               end
            end
            S_START: begin
               if (tick_c) begin
                  if (!rx_q2) begin
                     state <= S_DATA;
                     idx   <= '0;
                     timer <= RELOAD;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_DATA: begin
               if (tick_c) begin
                  shreg[idx] <= rx_q2;
                  timer      <= RELOAD;
                  if (idx == 3'd7) state <= S_STOP;
                  else             idx   <= idx + 3'd1;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_STOP: begin
               if (tick_c) begin
                  if (rx_q2) begin
                     state <= S_IDLE;
                  end else begin
                     frame_err_o <= 1'b1;
                     state       <= S_BREAK;
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_BREAK: begin
               if (rx_q2) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          pop_c, full_c, push_ok_c, drop_c;
   logic [AW:0]   wr_nxt_c, rd_nxt_c;
   logic [LW-1:0] level_nxt_c;
   logic [7:0]    head_c;

   assign pop_c       = out.valid_o & out.ready_i;
   assign full_c      = (out.level_o == LW'(FIFO_DEPTH));
   assign push_ok_c   = push_c & (~full_c | pop_c);
   assign drop_c      = push_c & full_c & ~pop_c;
   assign wr_nxt_c    = wr_ptr + LW'(push_ok_c);
   assign rd_nxt_c    = rd_ptr + LW'(pop_c);
   assign level_nxt_c = wr_nxt_c - rd_nxt_c;
   // A byte pushed into an (effectively) empty FIFO becomes the head directly
   assign head_c = (push_ok_c && (rd_nxt_c == wr_ptr)) ? shreg : mem[rd_nxt_c[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (push_ok_c) mem[wr_ptr[AW-1:0]] <= shreg;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         out.level_o <= '0;
         out.valid_o <= 1'b0;
         out.data_o  <= '0;
         overflow_o  <= 1'b0;
      end else begin
         wr_ptr      <= wr_nxt_c;
         rd_ptr      <= rd_nxt_c;
         out.level_o <= level_nxt_c;
         out.valid_o <= (level_nxt_c != '0);
         if (level_nxt_c != '0) out.data_o <= head_c;
         if (drop_c)     overflow_o <= 1'b1;
         else if (clr_i) overflow_o <= 1'b0;
      end
   end

`ifdef GUINEVEER_UART_RX_EOT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          eot_o <= 1'b0;
      else if (push_c && shreg == 8'h04)    eot_o <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_guineveer_uart_rx_monitor.sv
// Directed bench for the UART RX monitor: framing, glitch, errors, FIFO, reset.
module tb_guineveer_uart_rx_monitor;
   localparam int unsigned N     = 289;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic clr = 1'b0;
   logic frame_err, overflow;
`ifdef GUINEVEER_UART_RX_EOT_EN
   logic eot;
`endif
   int tests = 0;
   int fails = 0;
   int fe_cnt = 0;

   guineveer_uart_rx_monitor_if #(.FIFO_DEPTH(DEPTH)) bus ();

   guineveer_uart_rx_monitor #(.CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rx_i        (rx),
      .clr_i       (clr),
      .frame_err_o (frame_err),
      .overflow_o  (overflow),
      .out         (bus.master)
`ifdef GUINEVEER_UART_RX_EOT_EN
      ,
      .eot_o       (eot)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (frame_err === 1'b1) fe_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one frame starting at the current negedge; ends on a negedge
   task automatic send_frame(input logic [7:0] b, input bit stop_low);
      rx = 1'b0;
      repeat (N) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (N) @(negedge clk);
      end
      if (stop_low) begin
         rx = 1'b0;
         repeat (2 * N) @(negedge clk);
      end
      rx = 1'b1;
      repeat (N) @(negedge clk);
   endtask

   task automatic pop_one();
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.ready_i = 1'b0;
   endtask

   initial begin
      bus.ready_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(bus.valid_o), 32'd0);
      check("rst_level", 32'(bus.level_o), 32'd0);
      check("rst_data", 32'(bus.data_o), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send_frame(8'h55, 1'b0);
      check("t1_valid", 32'(bus.valid_o), 32'd1);
      check("t1_data", 32'(bus.data_o), 32'h55);
      check("t1_level", 32'(bus.level_o), 32'd1);
      check("t1_ferr", 32'(fe_cnt), 32'd0);
      pop_one();
      check("t1_pop_level", 32'(bus.level_o), 32'd0);

      rx = 1'b0;
      repeat (100) @(negedge clk);
      rx = 1'b1;
      repeat (N) @(negedge clk);
      check("t2_level", 32'(bus.level_o), 32'd0);
      check("t2_ferr", 32'(fe_cnt), 32'd0);

      send_frame(8'hA5, 1'b1);
      check("t3_ferr_pulses", 32'(fe_cnt), 32'd1);
      check("t3_level", 32'(bus.level_o), 32'd0);
      send_frame(8'h3C, 1'b0);
      check("t3_next_data", 32'(bus.data_o), 32'h3C);
      check("t3_next_level", 32'(bus.level_o), 32'd1);
      check("t3_ferr_after", 32'(fe_cnt), 32'd1);
      pop_one();

      for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0);
      check("t4_level", 32'(bus.level_o), 32'd8);
      check("t4_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t4_drain%0d", i), 32'(bus.data_o), 32'(i));
         pop_one();
      end
      check("t4_empty_level", 32'(bus.level_o), 32'd0);
      check("t4_empty_valid", 32'(bus.valid_o), 32'd0);
      check("t4_ovf_sticky", 32'(overflow), 32'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("t4_ovf_clr", 32'(overflow), 32'd0);

      for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b0);
      check("t5_full", 32'(bus.level_o), 32'd8);
      // Stop tick lands on the 2748th posedge after the start-bit negedge
      fork
         send_frame(8'h08, 1'b0);
         begin
            repeat (2747) @(posedge clk);
            @(negedge clk) bus.ready_i = 1'b1;
            @(negedge clk) bus.ready_i = 1'b0;
         end
      join
      check("t5_level", 32'(bus.level_o), 32'd8);
      check("t5_ovf", 32'(overflow), 32'd0);
      for (int i = 1; i < 9; i++) begin
         check($sformatf("t5_drain%0d", i), 32'(bus.data_o), 32'(i));
         pop_one();
      end
      check("t5_empty", 32'(bus.level_o), 32'd0);

`ifdef GUINEVEER_UART_RX_EOT_EN
      send_frame(8'h48, 1'b0);
      check("t6_eot_before", 32'(eot), 32'd0);
      send_frame(8'h04, 1'b0);
      check("t6_eot", 32'(eot), 32'd1);
      check("t6_level", 32'(bus.level_o), 32'd2);
      check("t6_head0", 32'(bus.data_o), 32'h48);
      pop_one();
      check("t6_head1", 32'(bus.data_o), 32'h04);
`endif

      send_frame(8'h77, 1'b0);
      check("t6_pre_level", 32'(bus.level_o), 32'd1);
      rx = 1'b0;
      repeat (3 * N) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_valid", 32'(bus.valid_o), 32'd0);
      check("t6_rst_level", 32'(bus.level_o), 32'd0);
      check("t6_rst_data", 32'(bus.data_o), 32'd0);
      check("t6_rst_ovf", 32'(overflow), 32'd0);
      check("t6_rst_ferr", 32'(frame_err), 32'd0);
`ifdef GUINEVEER_UART_RX_EOT_EN
      check("t6_rst_eot", 32'(eot), 32'd0);
`endif
      rx = 1'b1;
      rst_n = 1'b1;
      repeat (8 * N) @(negedge clk);
      check("t6_post_level", 32'(bus.level_o), 32'd0);
      send_frame(8'hC3, 1'b0);
      check("t6_post_data", 32'(bus.data_o), 32'hC3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
